// File: rtl/i_cache_pkg.sv
// Shared definitions for the instruction cache: default word width, FSM
// state encodings and the address-split width helpers.
package i_cache_pkg;

  localparam int IC_WORD_SIZE = 16;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } ic_state_e;

  function automatic int ic_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int ic_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int ic_tag_w(input int word_size, input int line_words, input int num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// Fetch-port and line-fill bus of the instruction cache; the cache sits on
// the slave modport, the CPU/memory side (or a bench) on the master modport.
interface i_cache_if
  import i_cache_pkg::*;
#(
  parameter int WORD_SIZE  = IC_WORD_SIZE,
  parameter int LINE_WORDS = 4
);
  logic                            readM1;
  logic [WORD_SIZE-1:0]            address1;
  logic [WORD_SIZE-1:0]            data1;
  logic                            i_ready;
  logic                            mem_read;
  logic [WORD_SIZE-1:0]            mem_address;
  logic [WORD_SIZE*LINE_WORDS-1:0] mem_data;
  logic                            mem_ready;
  logic [WORD_SIZE-1:0]            hit_count;
  logic [WORD_SIZE-1:0]            miss_count;

  modport slave (
    input  readM1, address1, mem_data, mem_ready,
    output data1, i_ready, mem_read, mem_address, hit_count, miss_count
  );

  modport master (
    output readM1, address1, mem_data, mem_ready,
    input  data1, i_ready, mem_read, mem_address, hit_count, miss_count
  );
endinterface

// File: rtl/i_cache_array.sv
// Direct-mapped line storage: valid/tag/data per line with an asynchronous
// word read port and a clocked whole-line write port.
module i_cache_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int OFF_W      = 2,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IDX_W-1:0]                rd_index,
  input  logic [OFF_W-1:0]                rd_offset,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [WORD_SIZE-1:0]            rd_word,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_index,
  input  logic [TAG_W-1:0]                wr_tag,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] wr_line
);
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
      for (int k = 0; k < LINE_WORDS; k++)
        data_q[wr_index][k] <= wr_line[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, line fill on
// miss with fetch stalled through i_ready, plus hit/miss counters.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int WORD_SIZE  = IC_WORD_SIZE,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic    Clk,
  input  logic    Reset,
  i_cache_if.slave bus
);
  localparam int OFF_W  = ic_off_w(LINE_WORDS);
  localparam int IDX_W  = ic_idx_w(NUM_LINES);
  localparam int TAG_W  = ic_tag_w(WORD_SIZE, LINE_WORDS, NUM_LINES);
  localparam int LINE_W = WORD_SIZE - OFF_W;

  ic_state_e            state_q, state_d;
  logic [LINE_W-1:0]    line_addr_q, line_addr_d;
  logic [WORD_SIZE-1:0] hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0] miss_count_q, miss_count_d;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 line_we;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] data1;

  i_cache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .OFF_W     (OFF_W),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (Clk),
    .rst      (Reset),
    .rd_index (bus.address1[OFF_W +: IDX_W]),
    .rd_offset(bus.address1[OFF_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    // Reset beats a simultaneous mem_ready so a dying fill never lands.
    .wr_en    (line_we & ~Reset),
    .wr_index (line_addr_q[IDX_W-1:0]),
    .wr_tag   (line_addr_q[LINE_W-1 -: TAG_W]),
    .wr_line  (bus.mem_data)
  );

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    i_ready      = 1'b0;
    data1        = '0;
    case (state_q)
      IC_IDLE: begin
        if (!bus.readM1) begin
          i_ready = 1'b1;
        end else if (rd_valid && rd_tag == bus.address1[WORD_SIZE-1 -: TAG_W]) begin
          i_ready     = 1'b1;
          data1       = rd_word;
          hit_count_d = hit_count_q + WORD_SIZE'(1);
        end else begin
          line_addr_d  = bus.address1[WORD_SIZE-1:OFF_W];
          miss_count_d = miss_count_q + WORD_SIZE'(1);
          state_d      = IC_FILL;
        end
      end
      IC_FILL: begin
        if (bus.mem_ready) begin
          line_we = 1'b1;
          state_d = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IC_IDLE;
      line_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.i_ready     = i_ready;
  assign bus.data1       = data1;
  assign bus.mem_read    = (state_q == IC_FILL);
  assign bus.mem_address = {line_addr_q, {OFF_W{1'b0}}};
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;

endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: behavioural line memory (L=2), fetch scoreboard,
// vector table for hit/miss/counter behaviour, and multi-cycle corner cases.
module tb_i_cache;
  localparam int MEM_L = 2;

  logic Clk = 1'b0;
  logic Reset;

  i_cache_if #(.WORD_SIZE(16), .LINE_WORDS(4)) bus ();

  i_cache dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int mem_cnt = 0;
  bit rst_req = 1'b0;
  bit rst_on_ready = 1'b0;
  bit stray_ready = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] fills[$];

  typedef struct {
    bit          rst;
    logic [15:0] addr;
    int          stall;
    logic [15:0] maddr;
    logic [15:0] miss;
    logic [15:0] hit;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd4) return (a + 16'd1) * 16'h1111;
    return (a * 16'h0101) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bench cycle: memory model reacts, then CPU inputs are applied.
  task automatic step(input logic rd, input logic [15:0] a);
    @(negedge Clk);
    if (bus.mem_read === 1'b1) begin
      mem_cnt++;
      bus.mem_ready = (mem_cnt == MEM_L + 1);
      for (int k = 0; k < 4; k++)
        bus.mem_data[k*16 +: 16] = mem_word(bus.mem_address + 16'(k));
    end else begin
      mem_cnt = 0;
      bus.mem_ready = stray_ready;
    end
    Reset = rst_req | (rst_on_ready & bus.mem_ready);
    bus.readM1 = rd;
    bus.address1 = a;
    #1;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    rst_req = 1'b0;
    step(1'b0, 16'h0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'h1);
    chk("rst_data1", 32'(bus.data1), 32'h0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("rst_hit_count", 32'(bus.hit_count), 32'h0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'h0);
  endtask

  // Holds a fetch until i_ready; expected word goes through the scoreboard.
  task automatic fetch(input logic [15:0] a, output int stalls);
    bit done;
    logic prev_rd;
    done = 1'b0;
    prev_rd = 1'b0;
    stalls = 0;
    fills.delete();
    exp_q.push_back(mem_word(a));
    for (int c = 0; c < 20 && !done; c++) begin
      step(1'b1, a);
      if (bus.mem_read === 1'b1) begin
        if (!prev_rd) fills.push_back(bus.mem_address);
        else chk("mem_addr_hold", 32'(bus.mem_address), 32'(fills[$]));
        prev_rd = 1'b1;
      end else begin
        prev_rd = 1'b0;
      end
      if (bus.i_ready === 1'b1) begin
        chk($sformatf("data1@%h", a), 32'(bus.data1), 32'(exp_q.pop_front()));
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL fetch_timeout addr %h: i_ready never rose within 20 cycles", a);
      void'(exp_q.pop_front());
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int stalls;
    bit seen;
    Reset = 1'b1;
    bus.readM1 = 1'b0;
    bus.address1 = '0;
    bus.mem_ready = 1'b0;
    bus.mem_data = '0;

    vecs[0]  = '{1'b1, 16'h0000, 4, 16'h0000, 16'd1, 16'd1};
    vecs[1]  = '{1'b0, 16'h0001, 0, 16'h0000, 16'd1, 16'd2};
    vecs[2]  = '{1'b0, 16'h0002, 0, 16'h0000, 16'd1, 16'd3};
    vecs[3]  = '{1'b0, 16'h0003, 0, 16'h0000, 16'd1, 16'd4};
    vecs[4]  = '{1'b1, 16'h0000, 4, 16'h0000, 16'd1, 16'd1};
    vecs[5]  = '{1'b0, 16'h0010, 4, 16'h0010, 16'd2, 16'd2};
    vecs[6]  = '{1'b0, 16'h0000, 4, 16'h0000, 16'd3, 16'd3};
    vecs[7]  = '{1'b0, 16'h0002, 0, 16'h0000, 16'd3, 16'd4};
    vecs[8]  = '{1'b0, 16'h0007, 4, 16'h0004, 16'd4, 16'd5};
    vecs[9]  = '{1'b0, 16'h0005, 0, 16'h0000, 16'd4, 16'd6};
    vecs[10] = '{1'b0, 16'h0013, 4, 16'h0010, 16'd5, 16'd7};
    vecs[11] = '{1'b0, 16'hFFFF, 4, 16'hFFFC, 16'd6, 16'd8};

    // Idle period with a stray mem_ready that must not fill anything.
    do_reset();
    stray_ready = 1'b1;
    step(1'b0, 16'h0000);
    stray_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'($urandom));
      chk("idle_i_ready", 32'(bus.i_ready), 32'h1);
      chk("idle_mem_read", 32'(bus.mem_read), 32'h0);
      chk("idle_data1", 32'(bus.data1), 32'h0);
    end
    step(1'b0, 16'h0000);
    chk("idle_hit_count", 32'(bus.hit_count), 32'h0);
    chk("idle_miss_count", 32'(bus.miss_count), 32'h0);
    fetch(16'h0000, stalls);
    chk("stray_ready_ignored_stall", 32'(stalls), 32'd4);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].rst) do_reset();
      fetch(vecs[v].addr, stalls);
      chk($sformatf("v%0d_stall", v), 32'(stalls), 32'(vecs[v].stall));
      chk($sformatf("v%0d_fills", v), 32'(fills.size()), (vecs[v].stall > 0) ? 32'd1 : 32'd0);
      if (fills.size() > 0)
        chk($sformatf("v%0d_mem_address", v), 32'(fills[0]), 32'(vecs[v].maddr));
      chk($sformatf("v%0d_miss_count", v), 32'(bus.miss_count), 32'(vecs[v].miss));
      chk($sformatf("v%0d_hit_count", v), 32'(bus.hit_count), 32'(vecs[v].hit));
    end

    // Address changes mid-fill: the latched line still completes.
    do_reset();
    step(1'b1, 16'h0020);
    chk("chg_first_stall", 32'(bus.i_ready), 32'h0);
    fetch(16'h0004, stalls);
    chk("chg_stall", 32'(stalls), 32'd7);
    chk("chg_fill_count", 32'(fills.size()), 32'd2);
    if (fills.size() == 2) begin
      chk("chg_fill0", 32'(fills[0]), 32'h0020);
      chk("chg_fill1", 32'(fills[1]), 32'h0004);
    end
    chk("chg_miss_count", 32'(bus.miss_count), 32'd2);
    fetch(16'h0020, stalls);
    chk("chg_0020_hit_stall", 32'(stalls), 32'd0);

    // Reset coincident with mem_ready: line discarded, counters cleared.
    do_reset();
    step(1'b1, 16'h0030);
    chk("rr_miss_stall", 32'(bus.i_ready), 32'h0);
    rst_on_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b1, 16'h0030);
      if (bus.mem_ready === 1'b1) seen = 1'b1;
    end
    rst_on_ready = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL rr_timeout: mem_ready never pulsed during fill");
    end
    step(1'b0, 16'h0000);
    chk("rr_i_ready", 32'(bus.i_ready), 32'h1);
    chk("rr_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rr_miss_count", 32'(bus.miss_count), 32'h0);
    chk("rr_hit_count", 32'(bus.hit_count), 32'h0);
    fetch(16'h0030, stalls);
    chk("rr_refetch_stall", 32'(stalls), 32'd4);
    chk("rr_refetch_miss", 32'(bus.miss_count), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_cache.md
# i_cache

Direct-mapped, read-only instruction cache between the pipelined CPU's fetch port (readM1/address1/data1) and a multi-cycle instruction memory that returns a whole line per request. A hit returns the instruction in the same cycle. A miss stalls fetch via `i_ready` while a line fill runs. The block keeps hit and miss counters for performance reporting next to `num_inst`.

## Interface
Parameters:
- `WORD_SIZE`, 16, instruction/address width.
- `LINE_WORDS`, 4, words per line (power of 2).
- `NUM_LINES`, 4, lines in the cache (power of 2).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `Clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `readM1`  in  1  CPU fetch request.
- `address1`  in  WORD_SIZE  CPU fetch word address.
- `data1`  out  WORD_SIZE  fetched instruction; valid when `i_ready`=1.
- `i_ready`  out  1  hit this cycle; 0 means the CPU must stall fetch.
- `mem_read`  out  1  line-fill request to memory.
- `mem_address`  out  WORD_SIZE  line-aligned address (offset bits 0).
- `mem_data`  in  WORD_SIZE*LINE_WORDS  returned line; word k is at bits [k*WORD_SIZE +: WORD_SIZE].
- `mem_ready`  in  1  one-cycle pulse; `mem_data` is valid in that cycle.
- `hit_count`  out  WORD_SIZE  number of hit cycles.
- `miss_count`  out  WORD_SIZE  number of misses.

## Operation
- Address split for the default parameters: offset = address1[1:0], index = address1[3:2], tag = address1[15:4]. In general: offset width = log2(LINE_WORDS), index width = log2(NUM_LINES), tag = remaining upper bits.
- Storage: per line, a valid bit, a tag, and LINE_WORDS data words. Reads are asynchronous; writes are clocked.
- Hit = `readM1` & valid[index] & (tag[index] == tag). On a hit, `data1` = the addressed word and `i_ready`=1, combinationally, in state IDLE only.
- FSM states: IDLE and FILL.
  - IDLE: if `readM1` and not a hit, latch the line address into `mem_address`, increment `miss_count`, and go to FILL.
  - IDLE with `readM1`=0: `i_ready`=1 and `data1`=0. This is a no-stall state, and no counter changes.
  - FILL: `mem_read`=1, `mem_address` held, `i_ready`=0. When `mem_ready`=1, write the whole line, set the valid bit, store the tag, and go to IDLE.
- `hit_count` increments in every IDLE cycle that has a hit. Both counters wrap at 2^WORD_SIZE.
- Changes to `address1` or `readM1` during FILL do not abort the fill. The latched line is always completed. After return to IDLE, the current `address1` is compared afresh.
- `mem_ready` received in IDLE is ignored.
- The cache never writes back; it holds no dirty state.

## Timing
- Reset values: all valid bits 0, state IDLE, `mem_read`=0, `mem_address`=0, `hit_count`=0, `miss_count`=0, `i_ready`=1 (combinational from IDLE with `readM1`=0), `data1`=0.
- Hit latency is 0 cycles: the instruction is on `data1` in the same cycle as the request.
- Miss timeline:
  - Cycle 0: miss detected, `i_ready`=0.
  - Cycle 1: `mem_read` rises.
  - Memory asserts `mem_ready` L cycles after it first samples `mem_read`=1.
  - At that edge the line is written and the FSM returns to IDLE.
  - The next cycle is a hit.
  - Total stall is L+2 cycles.
- `mem_read` stays high and `mem_address` stays stable until the edge on which `mem_ready`=1 is sampled. `mem_read` drops in the following cycle.
- Reset during FILL: the FSM goes to IDLE, all lines are invalidated, and `mem_read` drops the next cycle. A late `mem_ready` is ignored.
- When `Reset` and `mem_ready` are high together, reset wins and the line is not written.

## Structure
- Shared package/header (alongside `opcodes.v`) holds:
  - `WORD_SIZE`.
  - The FSM state encodings `IC_IDLE` and `IC_FILL`.
  - Tag/index/offset width derivation macros.
- One natural sub-module: `i_cache_array`. It holds valid/tag/data storage, with an async read port and a clocked line-write port, so a future data cache can reuse it.
- `i_cache` itself contains the FSM, hit logic, and counters.

## Test plan
- Reset, then fetch 0x0000 with a memory of L=2 returning line {0x1111,0x2222,0x3333,0x4444}.
  - Expect `i_ready`=0 for 4 cycles, `mem_address`=0x0000, and `miss_count`=1.
  - Next cycle: `data1`=0x1111, `i_ready`=1.
- After the fill, fetch 0x0001, 0x0002, 0x0003 on consecutive cycles.
  - Expect `data1` = 0x2222, 0x3333, 0x4444, `i_ready`=1 throughout, and `hit_count` increasing by 3.
  - No `mem_read` is issued.
- Conflict: fetch 0x0000, then 0x0010 (same index, tag 1), then 0x0000.
  - Expect three misses (`miss_count`=3), with `mem_address` = 0x0000, 0x0010, 0x0000.
- Change `address1` from 0x0020 to 0x0004 during FILL.
  - The fill completes for 0x0020.
  - Back in IDLE, 0x0004 misses, giving a second fill with `mem_address`=0x0004.
- Assert `Reset` in the cycle `mem_ready`=1 arrives during FILL.
  - Expect IDLE, valid cleared, and counters 0.
  - Refetching the same address misses.
- `readM1`=0 for 10 cycles.
  - Expect no counter change, `mem_read`=0, and `i_ready`=1.
